// File: rtl/rle_pkg.sv
// Shared constants and types for the run-length encoder.
// Symbol/count widths, FSM state enum and code-word bundle.
package rle_pkg;

  localparam int DATA_W = 7;
  localparam int CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic              tag;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] symbol;
  } rle_word_t;

endpackage

// File: rtl/rle_encoder_datapath.sv
// Run-length datapath: held symbol, match compare, saturating
// counter and registered code-word output.
// Ports: clock, reset_n, data_in, load/inc/emit strobes in;
//        match, sat, out_valid, out_word out.
import rle_pkg::*;

module rle_datapath (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  input  logic              inc,
  input  logic              emit,
  output logic              match,
  output logic              sat,
  output logic              out_valid,
  output rle_word_t         out_word
);

  logic [DATA_W-1:0] held;
  logic [CNT_W-1:0]  run_cnt;

  assign match = (data_in == held);
  assign sat   = (run_cnt == CNT_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held    <= '0;
      run_cnt <= '0;
    end else if (load) begin
      held    <= data_in;
      run_cnt <= CNT_W'(1);
    end else if (inc) begin
      run_cnt <= run_cnt + CNT_W'(1);
    end
  end

  // emit captures the old run even when load replaces it this cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_word  <= '0;
    end else begin
      out_valid <= emit;
      if (emit) begin
        out_word.tag    <= (run_cnt > CNT_W'(1));
        out_word.count  <= run_cnt;
        out_word.symbol <= held;
      end
    end
  end

endmodule

// File: rtl/rle_encoder_core.sv
// Run-length encoder core: FSM driving the rle_datapath.
// Ports: clock, reset_n, in_valid, data_in, flush in;
//        out_valid, out_tag, out_count, out_symbol out.
import rle_pkg::*;

module rle_encoder_core (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flush,
  output logic              out_valid,
  output logic              out_tag,
  output logic [CNT_W-1:0]  out_count,
  output logic [DATA_W-1:0] out_symbol
);

  logic      rst_meta;
  logic      rst_n_s;
  state_t    state;
  logic      load;
  logic      inc;
  logic      emit;
  logic      match;
  logic      sat;
  rle_word_t out_word;

  // async assert, release synchronised to clock
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta <= 1'b0;
      rst_n_s  <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n_s  <= rst_meta;
    end
  end

  always_comb begin
    load = 1'b0;
    inc  = 1'b0;
    emit = 1'b0;
    unique case (state)
      IDLE: begin
        load = in_valid;
      end
      RUN: begin
        if (flush) begin
          emit = 1'b1;
          load = in_valid;
        end else if (in_valid) begin
          if (match && !sat) begin
            inc = 1'b1;
          end else begin
            emit = 1'b1;
            load = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: if (in_valid) state <= RUN;
        RUN:  if (flush && !in_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  rle_datapath u_dp (
    .clock     (clock),
    .reset_n   (rst_n_s),
    .data_in   (data_in),
    .load      (load),
    .inc       (inc),
    .emit      (emit),
    .match     (match),
    .sat       (sat),
    .out_valid (out_valid),
    .out_word  (out_word)
  );

  assign out_tag    = out_word.tag;
  assign out_count  = out_word.count;
  assign out_symbol = out_word.symbol;

endmodule

// File: tb/tb_rle_encoder_core.sv
// Directed scoreboard bench for rle_encoder_core.
// Expected words are queued as stimulus is driven.
import rle_pkg::*;

module tb_rle_encoder_core;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_tag;
  logic [CNT_W-1:0]  out_count;
  logic [DATA_W-1:0] out_symbol;

  int n_assert = 0;
  int n_fail   = 0;
  rle_word_t sb[$];

  always #5 clock = ~clock;

  rle_encoder_core dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_tag    (out_tag),
    .out_count  (out_count),
    .out_symbol (out_symbol)
  );

  function automatic rle_word_t mk(
    input logic t, input int c, input logic [DATA_W-1:0] s
  );
    rle_word_t w;
    w.tag    = t;
    w.count  = CNT_W'(c);
    w.symbol = s;
    return w;
  endfunction

  task automatic chk(
    input string tag, input logic [31:0] obs, input logic [31:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, optionally expect a word after the edge
  task automatic cyc(
    input logic v, input logic [DATA_W-1:0] d, input logic f,
    input logic e, input rle_word_t w
  );
    rle_word_t x;
    if (e) sb.push_back(w);
    in_valid = v;
    data_in  = d;
    flush    = f;
    @(posedge clock);
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, e});
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 32'd1, 32'd0);
      end else begin
        x = sb.pop_front();
        chk("word", {16'b0, out_tag, out_count, out_symbol},
            {16'b0, x});
      end
    end
  endtask

  task automatic sym(input logic [DATA_W-1:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, '0);
  endtask

  task automatic sym_e(input logic [DATA_W-1:0] d, input rle_word_t w);
    cyc(1'b1, d, 1'b0, 1'b1, w);
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    do_reset();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_word", {16'b0, out_tag, out_count, out_symbol}, 32'd0);
    chk("rst_state", {31'b0, dut.state}, {31'b0, IDLE});
    chk("rst_run_cnt", {24'b0, dut.u_dp.run_cnt}, 32'd0);

    // idle flush pulses produce nothing
    repeat (3) cyc(1'b0, 7'h55, 1'b1, 1'b0, '0);
    idle();

    // basic runs
    sym(7'h05);
    sym(7'h05);
    sym(7'h05);
    sym_e(7'h12, mk(1'b1, 3, 7'h05));
    sym_e(7'h07, mk(1'b0, 1, 7'h12));
    cyc(1'b0, '0, 1'b1, 1'b1, mk(1'b0, 1, 7'h07));
    chk("basic_idle", {31'b0, dut.state}, {31'b0, IDLE});
    idle();

    // saturation: 300 x 0x2A splits into 255 + 45
    for (int i = 1; i <= 300; i++) begin
      if (i == 256) sym_e(7'h2A, mk(1'b1, 255, 7'h2A));
      else          sym(7'h2A);
    end
    sym_e(7'h00, mk(1'b1, 45, 7'h2A));
    cyc(1'b0, '0, 1'b1, 1'b1, mk(1'b0, 1, 7'h00));
    idle();

    // gaps do not break a run
    sym(7'h01);
    idle();
    idle();
    sym(7'h01);
    cyc(1'b0, '0, 1'b1, 1'b1, mk(1'b1, 2, 7'h01));
    idle();

    // flush with matching input still emits
    sym(7'h33);
    sym(7'h33);
    cyc(1'b1, 7'h33, 1'b1, 1'b1, mk(1'b1, 2, 7'h33));
    cyc(1'b0, '0, 1'b1, 1'b1, mk(1'b0, 1, 7'h33));
    chk("flush_idle", {31'b0, dut.state}, {31'b0, IDLE});
    idle();

    // reset mid-run discards the run
    repeat (4) sym(7'h0F);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_word", {16'b0, out_tag, out_count, out_symbol}, 32'd0);
    chk("midrst_state", {31'b0, dut.state}, {31'b0, IDLE});
    @(posedge clock);
    #3 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    idle();
    sym(7'h10);
    cyc(1'b0, '0, 1'b1, 1'b1, mk(1'b0, 1, 7'h10));
    idle();
    idle();

    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
